batch_scheduler: RTL and testbench

BATCH_SCHEDULER -- requirements
Module: batch_scheduler

---
 rtl/batch_scheduler.sv | 116 +++++++++++
 tb/tb_batch_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/batch_scheduler.sv
// Batch scheduler: walks a file index range, launching the processing unit once per
// file and waiting (with a timeout) for its finish before moving to the next index.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for go; results of the last batch are held
// LAUNCH | start pulse for file cur; finish timer cleared
// WAIT   | waiting for finish, timer running toward timeout
// NEXT   | one gap cycle, cur advances to the next index
// DONE   | batch over; done pulse follows on the way back to IDLE
module batch_scheduler #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int IDX_W          = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [IDX_W-1:0] first_idx,
    input  logic [IDX_W-1:0] last_idx,
    input  logic             abort,
    input  logic             finish,
    output logic             start,
    output logic [IDX_W-1:0] file_index,
    output logic             busy,
    output logic             done,
    output logic             timeout_err,
    output logic [IDX_W:0]   files_done
);

    localparam int TMR_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_NEXT   = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] cur;
    logic [IDX_W-1:0] last_q;
    logic [TMR_W-1:0] timer;
    logic             abort_q;

    assign file_index = cur;
    assign busy       = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            cur         <= '0;
            last_q      <= '0;
            timer       <= '0;
            abort_q     <= 1'b0;
            start       <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            files_done  <= '0;
        end else begin
            start <= 1'b0;
            done  <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (go) begin
                        files_done <= '0;
                        if (first_idx <= last_idx) begin
                            cur         <= first_idx;
                            last_q      <= last_idx;
                            timeout_err <= 1'b0;
                            abort_q     <= 1'b0;
                            start       <= 1'b1;
                            state       <= ST_LAUNCH;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_LAUNCH: begin
                    timer <= '0;
                    if (abort) abort_q <= 1'b1;
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // finish has priority over a timeout landing in the same cycle
                    if (finish) begin
                        files_done <= files_done + 1'b1;
                        if (cur == last_q || abort || abort_q) state <= ST_DONE;
                        else                                   state <= ST_NEXT;
                    end else if (timer == TMR_LAST) begin
                        timeout_err <= 1'b1;
                        state       <= ST_DONE;
                    end else begin
                        timer <= timer + 1'b1;
                        if (abort) abort_q <= 1'b1;
                    end
                end
                ST_NEXT: begin
                    // only reached when cur != last, so the increment cannot wrap
                    cur   <= cur + 1'b1;
                    if (abort) abort_q <= 1'b1;
                    start <= 1'b1;
                    state <= ST_LAUNCH;
                end
                ST_DONE: begin
                    done    <= 1'b1;
                    abort_q <= 1'b0;
                    state   <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_batch_scheduler.sv
// Directed bench for batch_scheduler: normal, empty, timeout, abort, boundary and
// mid-batch reset scenarios with hand-computed expectations.
module tb_batch_scheduler;

    localparam int IDX_W = 10;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             go = 1'b0;
    logic [IDX_W-1:0] first_idx = '0;
    logic [IDX_W-1:0] last_idx = '0;
    logic             abort = 1'b0;
    logic             finish = 1'b0;
    logic             start;
    logic [IDX_W-1:0] file_index;
    logic             busy;
    logic             done;
    logic             timeout_err;
    logic [IDX_W:0]   files_done;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int start_base;
    int done_base;

    batch_scheduler #(.TIMEOUT_CYCLES(16), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .go(go), .first_idx(first_idx), .last_idx(last_idx),
        .abort(abort), .finish(finish), .start(start), .file_index(file_index),
        .busy(busy), .done(done), .timeout_err(timeout_err), .files_done(files_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (start) start_cnt <= start_cnt + 1;
        if (done)  done_cnt  <= done_cnt + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue_go(input logic [IDX_W-1:0] f, input logic [IDX_W-1:0] l);
        go = 1'b1;
        first_idx = f;
        last_idx = l;
        tick();
        go = 1'b0;
    endtask

    // Entered in the LAUNCH cycle; leaves right after the finish edge.
    task automatic run_file(input logic [IDX_W-1:0] idx, input bit abort_mid);
        check("launch_start", start, 1);
        check("launch_index", file_index, idx);
        for (int i = 0; i < 9; i++) begin
            if (abort_mid && i == 3) abort = 1'b1;
            tick();
            abort = 1'b0;
        end
        check("wait_index", file_index, idx);
        check("wait_start_low", start, 0);
        check("wait_busy", busy, 1);
        finish = 1'b1;
        tick();
        finish = 1'b0;
    endtask

    initial begin
        // reset state
        tick(2);
        check("rst_start", start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_terr", timeout_err, 0);
        check("rst_fdone", files_done, 0);
        check("rst_index", file_index, 0);
        #2 rst = 1'b1;
        tick(2);
        check("idle_busy", busy, 0);

        // normal batch 3..5
        start_base = start_cnt;
        done_base = done_cnt;
        issue_go(10'd3, 10'd5);
        check("norm_busy", busy, 1);
        run_file(10'd3, 1'b0);
        check("norm_next_gap", start, 0);
        tick();
        run_file(10'd4, 1'b0);
        tick();
        run_file(10'd5, 1'b0);
        check("norm_done_state", done, 0);
        tick();
        check("norm_done", done, 1);
        check("norm_busy_end", busy, 0);
        check("norm_fdone", files_done, 3);
        check("norm_terr", timeout_err, 0);
        tick();
        check("norm_done_pulse", done, 0);
        check("norm_hold_fdone", files_done, 3);
        check("norm_starts", start_cnt - start_base, 3);
        check("norm_dones", done_cnt - done_base, 1);

        // empty range 7..2
        start_base = start_cnt;
        issue_go(10'd7, 10'd2);
        check("empty_start", start, 0);
        check("empty_busy", busy, 1);
        check("empty_done_early", done, 0);
        tick();
        check("empty_done", done, 1);
        check("empty_fdone", files_done, 0);
        tick(3);
        check("empty_starts", start_cnt - start_base, 0);

        // timeout 0..4, finish never returned
        start_base = start_cnt;
        issue_go(10'd0, 10'd4);
        check("to_start", start, 1);
        tick(16);
        check("to_terr_early", timeout_err, 0);
        check("to_busy", busy, 1);
        tick();
        check("to_terr", timeout_err, 1);
        check("to_done_early", done, 0);
        tick();
        check("to_done", done, 1);
        check("to_fdone", files_done, 0);
        tick(3);
        check("to_terr_hold", timeout_err, 1);
        check("to_starts", start_cnt - start_base, 1);
        finish = 1'b1;
        tick();
        finish = 1'b0;
        check("idle_finish_ignored", files_done, 0);

        // abort during file 2 of 0..9
        start_base = start_cnt;
        done_base = done_cnt;
        issue_go(10'd0, 10'd9);
        check("ab_terr_clear", timeout_err, 0);
        run_file(10'd0, 1'b0);
        tick();
        run_file(10'd1, 1'b0);
        tick();
        run_file(10'd2, 1'b1);
        check("ab_no_next", start, 0);
        tick();
        check("ab_done", done, 1);
        check("ab_fdone", files_done, 3);
        tick(4);
        check("ab_starts", start_cnt - start_base, 3);
        check("ab_dones", done_cnt - done_base, 1);

        // boundary 1023..1023
        start_base = start_cnt;
        issue_go(10'd1023, 10'd1023);
        run_file(10'd1023, 1'b0);
        tick();
        check("bd_done", done, 1);
        check("bd_fdone", files_done, 1);
        tick(4);
        check("bd_nowrap", file_index, 1023);
        check("bd_starts", start_cnt - start_base, 1);

        // reset mid-WAIT
        done_base = done_cnt;
        issue_go(10'd2, 10'd6);
        tick(4);
        rst = 1'b0;
        #2;
        check("mr_start", start, 0);
        check("mr_busy", busy, 0);
        check("mr_done", done, 0);
        check("mr_terr", timeout_err, 0);
        check("mr_fdone", files_done, 0);
        check("mr_index", file_index, 0);
        tick(3);
        #2 rst = 1'b1;
        tick(3);
        check("mr_no_done", done_cnt - done_base, 0);
        check("mr_idle", busy, 0);
        issue_go(10'd4, 10'd4);
        run_file(10'd4, 1'b0);
        tick();
        check("mr_after_done", done, 1);
        check("mr_after_fdone", files_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
